// File: rtl/stopwatch_count_ctrl.sv
// stopwatch_count_ctrl
//   Up/down time counter for the stopwatch. It has run control (IDLE/RUN/PAUSE/DONE),
//   inclusive limits [MIN_VAL, MAX_VAL], a wrap-or-hold limit mode and a clamped
//   preset load. COUNT drives the display decoder. The status flags go to the
//   top-level control.
//
//   Optional build macro: LAP_CAPTURE_EN adds lap capture (lap_i, lap_count_o,
//   lap_valid_o). The default build leaves the macro undefined and has no lap logic.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      level, request run
//   stop_i       level, request pause (wins over start_i)
//   clear_i      return to RST_VAL and IDLE
//   op_i         0 = count up, 1 = count down (sampled on tick)
//   tick_i       one-cycle count-enable strobe
//   wrap_i       1 = wrap at a limit, 0 = hold and go to DONE (sampled on tick)
//   load_i       load clamped load_val_i (ignored while running)
//   load_val_i   preset value
//   count_o      current count
//   running_o    high in RUN
//   done_o       high in DONE
//   term_o       one-cycle pulse on each limit event
//   lap_i        (LAP_CAPTURE_EN) capture count in RUN/PAUSE
//   lap_count_o  (LAP_CAPTURE_EN) captured count
//   lap_valid_o  (LAP_CAPTURE_EN) capture holds a value
module stopwatch_count_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 5999,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             op_i,
  input  logic             tick_i,
  input  logic             wrap_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
`ifdef LAP_CAPTURE_EN
  input  logic             lap_i,
  output logic [WIDTH-1:0] lap_count_o,
  output logic             lap_valid_o,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             done_o,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             term_q, term_d;
  logic             running_q, done_q;

  // Less-than test against MIN_C. A constant 1 is prepended to both sides so the
  // comparison stays well-formed when MIN_C is zero.
  function automatic logic below_min(input logic [WIDTH-1:0] v);
    return {1'b1, v} < {1'b1, MIN_C};
  endfunction

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (below_min(v))  return MIN_C;
    else if (v > MAX_C) return MAX_C;
    else                return v;
  endfunction

  // One bit wider than the count. Overflow and borrow become ordinary compare
  // results, so a modular wrap never reaches count_q.
  logic [WIDTH:0] count_inc, count_dec;
  logic           up_hit, down_hit;

  assign count_inc = {1'b0, count_q} + (WIDTH+1)'(1);
  assign count_dec = {1'b0, count_q} - (WIDTH+1)'(1);
  assign up_hit    = count_inc > {1'b0, MAX_C};
  assign down_hit  = count_dec[WIDTH] | below_min(count_dec[WIDTH-1:0]);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = 1'b0;
    if (clear_i) begin
      state_d = S_IDLE;
      count_d = RST_C;
    end else if (load_i && (state_q != S_RUN)) begin
      state_d = S_IDLE;
      count_d = clamp_load(load_val_i);
    end else begin
      // A load in RUN falls through to here. stop_i then still takes effect.
      unique case (state_q)
        S_IDLE:  if (!stop_i && start_i) state_d = S_RUN;
        S_PAUSE: if (!stop_i && start_i) state_d = S_RUN;
        S_RUN: begin
          if (stop_i) begin
            state_d = S_PAUSE;
          end else if (tick_i) begin
            if (!op_i) begin
              if (!up_hit) begin
                count_d = count_inc[WIDTH-1:0];
              end else begin
                term_d = 1'b1;
                if (wrap_i) count_d = MIN_C;
                else        state_d = S_DONE;
              end
            end else begin
              if (!down_hit) begin
                count_d = count_dec[WIDTH-1:0];
              end else begin
                term_d = 1'b1;
                if (wrap_i) count_d = MAX_C;
                else        state_d = S_DONE;
              end
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      count_q   <= RST_C;
      term_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      term_q    <= term_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign count_o   = count_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign term_o    = term_q;

`ifdef LAP_CAPTURE_EN
  logic [WIDTH-1:0] lap_count_q;
  logic             lap_valid_q;

  // count_q is the pre-tick value when a tick lands in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lap_count_q <= '0;
      lap_valid_q <= 1'b0;
    end else if (lap_i && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
      lap_count_q <= count_q;
      lap_valid_q <= 1'b1;
    end
  end

  assign lap_count_o = lap_count_q;
  assign lap_valid_o = lap_valid_q;
`endif

endmodule

// File: doc/stopwatch_count_ctrl.md
Name: stopwatch_count_ctrl

Overview:
Parametrised successor to the fixed 16-bit per-bit add/subtract select stage. It is a complete up/down time counter with run control, configurable limits, wrap/hold mode and clamped preset load. All state is registered in the block. It drives the display decoder with COUNT and the top-level control with the status flags.

Parameters:
WIDTH, 16, counter width in bits
MIN_VAL, 0, lower count bound (inclusive)
MAX_VAL, 5999, upper count bound (inclusive); MIN_VAL < MAX_VAL < 2^WIDTH
RST_VAL, 0, COUNT value after RST and CLEAR; must lie in [MIN_VAL, MAX_VAL]

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
START  in  1  level; request run
STOP  in  1  level; request pause
CLEAR  in  1  return to RST_VAL and IDLE
OP  in  1  direction: 0 = count up, 1 = count down
TICK  in  1  one-cycle count-enable strobe (time base)
WRAP  in  1  limit mode: 1 = wrap around, 0 = hold at limit
LOAD  in  1  load LOAD_VAL into COUNT
LOAD_VAL  in  WIDTH  preset value
COUNT  out  WIDTH  current count
RUNNING  out  1  high while in RUN
DONE  out  1  high while in DONE
TERM  out  1  one-cycle pulse when a limit is crossed or reached

Behaviour:
- Reset (RST=1 at clock edge):
  - COUNT=RST_VAL, state=IDLE, RUNNING=0, DONE=0, TERM=0.
  - RST overrides all other inputs.
- States: IDLE, RUN, PAUSE, DONE. RUNNING and DONE are registered decodes of the state.
- Input priority, highest first: RST > CLEAR > LOAD > STOP > START > TICK.
- CLEAR: COUNT=RST_VAL, state=IDLE, TERM=0. Valid from any state.
- LOAD (in IDLE, PAUSE or DONE):
  - COUNT = LOAD_VAL clamped to [MIN_VAL, MAX_VAL].
  - State goes to IDLE; a load from DONE clears DONE.
  - LOAD in RUN is ignored.
- State transitions:
  - IDLE --START--> RUN
  - RUN --STOP--> PAUSE
  - PAUSE --START--> RUN
  - DONE --START--> DONE (start is ignored until CLEAR or LOAD)
  - If START and STOP are both high, STOP wins.
- Counting: happens only in RUN, when TICK=1 and no higher-priority input is active. The update is visible on COUNT in the cycle after the TICK edge (latency 1).
- Up-count (OP=0):
  - COUNT<MAX_VAL: COUNT+1.
  - COUNT==MAX_VAL, WRAP=1: COUNT=MIN_VAL, TERM pulses, stay in RUN.
  - COUNT==MAX_VAL, WRAP=0: COUNT holds MAX_VAL, state goes to DONE, TERM pulses.
- Down-count (OP=1): symmetric with MIN_VAL. With WRAP=1 the wrap target is MAX_VAL.
- Arithmetic: use WIDTH+1-bit intermediates; no modular overflow is ever visible on COUNT.
- OP and WRAP are sampled on each TICK. Changing either mid-run takes effect on the next TICK.
- TICK while in IDLE, PAUSE or DONE is ignored.
- TERM is high for exactly one cycle per limit event and is 0 otherwise.
- STOP arriving in the same cycle as a limit TICK: STOP wins; no count, no TERM.

Optional Feature:
LAP_CAPTURE_EN.
- Defined:
  - Adds input LAP (1 bit) and outputs LAP_COUNT (WIDTH bits) and LAP_VALID (1 bit).
  - LAP=1 in RUN or PAUSE latches the current COUNT (the pre-tick value if TICK occurs in the same cycle) into LAP_COUNT and sets LAP_VALID.
  - RST or CLEAR sets LAP_COUNT=0 and LAP_VALID=0.
  - LAP is ignored in IDLE and DONE.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset/hold: RST=1 for 2 cycles, then START=1 with TICK pulsed 5 times -> COUNT=0 during reset, then 5; RUNNING=1; DONE=0.
- Up wrap: LOAD_VAL=5998 with LOAD, START, WRAP=1, OP=0, 3 TICKs -> COUNT 5999, 0, 1; TERM high exactly on the cycle COUNT becomes 0.
- Down hold: LOAD_VAL=2, START, WRAP=0, OP=1, 4 TICKs -> COUNT 1, 0, 0, 0; DONE=1 after the third TICK with TERM pulsed once; later START has no effect.
- Clamp and priority: LOAD_VAL=65535 in IDLE -> COUNT=5999. Then in RUN, LOAD+STOP+TICK together -> LOAD ignored, goes to PAUSE, COUNT unchanged.
- CLEAR mid-run: COUNT=1234 in RUN, CLEAR and TICK in the same cycle -> COUNT=0, state IDLE, TERM=0.
- LAP_CAPTURE_EN: COUNT=40 in RUN, LAP and TICK in the same cycle -> LAP_COUNT=40, LAP_VALID=1, COUNT=41. Then CLEAR -> LAP_VALID=0.
